mem_estagio: RTL and testbench
==============================

Name: mem_estagio

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX stage.
- Consumes the EX results (ALU result as address, forwarded rt data as store data, destination register, control bits).
- Owns the data memory and performs byte/half/word loads and stores.
- Registers everything into the MEM/WB pipeline register and drives `registrado`, the write-back forwarding value, back to EX.

Parameters:
- ADDR_W, 10, word-address bits; data memory depth = 2^ADDR_W 32-bit words.

Ports:
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  freeze MEM/WB register and suppress stores
- flush  in  1  squash current instruction (bubble into WB)
- endereco  in  32  byte address (EX ALU result `final`)
- dadoEscrita  in  32  store data (EX `MuxS`)
- destinoRegIn  in  5  destination register from EX
- memRead  in  1  load enable
- memWrite  in  1  store enable
- memToRegIn  in  1  WB selects memory data
- regWriteIn  in  1  WB register write enable
- tamanho  in  2  access size: 00 byte, 01 half, 10/11 word
- semSinal  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend
- dadoLido  out  32  MEM/WB: extended load data
- resultadoAlu  out  32  MEM/WB: copy of endereco
- destinoReg  out  5  MEM/WB: destination register
- regWrite  out  1  MEM/WB: register write enable
- memToReg  out  1  MEM/WB: WB mux select
- registrado  out  32  combinational: memToReg ? dadoLido : resultadoAlu (forwarding to EX)
- erroAlinhamento  out  1  MEM/WB: misaligned access flag (see Optional Feature)

Behaviour:
- Reset:
  - Asynchronous and active-low.
  - All MEM/WB outputs go to 0, so `registrado` = 0.
  - Memory array contents are not reset.
- Latency: one cycle. Inputs sampled at edge N appear on MEM/WB outputs after edge N.
- Word index = endereco[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Lanes are little-endian:
  - byte lane = endereco[1:0], bits 8·lane+7 : 8·lane;
  - half lane = endereco[1], bits 16·lane+15 : 16·lane.
- Store:
  - Occurs on the rising edge when memWrite=1, stall=0 and flush=0.
  - Only the selected byte/half/word lanes are written, taken from the low bits of dadoEscrita. Other lanes are unchanged.
- Load:
  - When memRead=1, the addressed word is read and the lane extracted.
  - The result is sign- or zero-extended per semSinal (word ignores semSinal) and captured into dadoLido at the edge.
  - When memRead=0, dadoLido captures 0.
- memRead and memWrite both 1: the store is performed, and dadoLido captures the old word contents (read-before-write).
- A store at edge N followed by a load of the same address at edge N+1 returns the stored data (array already updated).
- Stall (flush=0): all MEM/WB registers hold; the store is suppressed.
- Flush has priority over stall:
  - regWrite, memToReg, erroAlinhamento, dadoLido, resultadoAlu and destinoReg load 0;
  - the store is suppressed.
- Reset asserted mid-operation: an in-flight store at that edge is lost, and outputs clear immediately.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN
- Defined:
  - Misaligned accesses are: half with endereco[0]=1, or word with endereco[1:0]≠0.
  - When memRead or memWrite is set and the access is misaligned, erroAlinhamento registers 1.
  - The store is suppressed, dadoLido captures 0, and regWrite captures 0.
- Not defined:
  - Misaligned low bits are ignored: half uses endereco[1], word uses bits [ADDR_W+1:2].
  - The access proceeds as aligned; erroAlinhamento is tied to 0.

Test Plan:
- Reset low mid-traffic -> all outputs 0 immediately; after release, a load from a previously stored address still returns the stored data.
- Word store 0xDEADBEEF @0x10, then word load @0x10 next cycle (memToRegIn=1) -> dadoLido=0xDEADBEEF and registrado=0xDEADBEEF one cycle after the load.
- Byte store 0x7F @0x21 over word 0 @0x20; LB @0x21 -> 0x0000007F. Byte store 0x80 @0x22; LB @0x22 -> 0xFFFFFF80; LBU @0x22 -> 0x00000080; LW @0x20 -> 0x00807F00.
- Half store 0xABCD @0x32; LH -> 0xFFFFABCD; LHU -> 0x0000ABCD. ALU op with regWriteIn=1, memToRegIn=0, endereco=0x1234 -> registrado=0x1234, destinoReg=destinoRegIn.
- stall=1 with memWrite=1 @0x40 (data 5) -> outputs unchanged and a later load @0x40 returns the old value. stall=1 and flush=1 together -> regWrite=0, memToReg=0, no write.
- With MEM_ALIGN_CHECK_EN: LW @0x42 -> erroAlinhamento=1, regWrite=0, dadoLido=0; SW @0x41 -> memory unchanged. Without the macro: LW @0x42 returns word @0x40, erroAlinhamento=0.

Source files
------------

// File: rtl/mem_estagio_if.sv
// EX -> MEM stage bus: EX results and control on the way in, MEM/WB register and
// the write-back forwarding value on the way out.
interface mem_estagio_if;
  logic [31:0] endereco;
  logic [31:0] dadoEscrita;
  logic [4:0]  destinoRegIn;
  logic        memRead;
  logic        memWrite;
  logic        memToRegIn;
  logic        regWriteIn;
  logic [1:0]  tamanho;
  logic        semSinal;

  logic [31:0] dadoLido;
  logic [31:0] resultadoAlu;
  logic [4:0]  destinoReg;
  logic        regWrite;
  logic        memToReg;
  logic [31:0] registrado;
  logic        erroAlinhamento;

  // master = EX side (drives the request, observes MEM/WB); slave = MEM stage.
  modport master (
    output endereco, dadoEscrita, destinoRegIn, memRead, memWrite,
           memToRegIn, regWriteIn, tamanho, semSinal,
    input  dadoLido, resultadoAlu, destinoReg, regWrite, memToReg,
           registrado, erroAlinhamento
  );

  modport slave (
    input  endereco, dadoEscrita, destinoRegIn, memRead, memWrite,
           memToRegIn, regWriteIn, tamanho, semSinal,
    output dadoLido, resultadoAlu, destinoReg, regWrite, memToReg,
           registrado, erroAlinhamento
  );
endinterface

// File: rtl/mem_estagio.sv
// MIPS MEM stage: byte/half/word data memory plus the MEM/WB pipeline register.
// Optional macro MEM_ALIGN_CHECK_EN flags and suppresses misaligned half/word accesses.
module mem_estagio #(
  parameter int ADDR_W = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  mem_estagio_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       load_val;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              mis;
  logic              we;

  assign idx     = bus.endereco[ADDR_W+1:2];
  assign lane    = bus.endereco[1:0];
  assign rd_word = mem[idx];
  assign sel_b   = rd_word[{lane, 3'b000} +: 8];
  assign sel_h   = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (bus.tamanho)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane[0];
      default: mis = |lane;
    endcase
    mis = mis & (bus.memRead | bus.memWrite);
`endif
  end

  // Load lane extraction; word accesses ignore semSinal.
  always_comb begin
    load_val = rd_word;
    case (bus.tamanho)
      2'b00:   load_val = bus.semSinal ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   load_val = bus.semSinal ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wdata = bus.dadoEscrita;
    be    = 4'b1111;
    case (bus.tamanho)
      2'b00: begin
        wdata = {4{bus.dadoEscrita[7:0]}};
        be    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{bus.dadoEscrita[15:0]}};
        be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = bus.dadoEscrita;
        be    = 4'b1111;
      end
    endcase
  end

  // Reset gates the write so a store sampled while reset is low is dropped.
  assign we = bus.memWrite & ~stall & ~flush & reset & ~mis;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.dadoLido        <= 32'h0;
      bus.resultadoAlu    <= 32'h0;
      bus.destinoReg      <= 5'h0;
      bus.regWrite        <= 1'b0;
      bus.memToReg        <= 1'b0;
      bus.erroAlinhamento <= 1'b0;
    end else if (flush) begin
      bus.dadoLido        <= 32'h0;
      bus.resultadoAlu    <= 32'h0;
      bus.destinoReg      <= 5'h0;
      bus.regWrite        <= 1'b0;
      bus.memToReg        <= 1'b0;
      bus.erroAlinhamento <= 1'b0;
    end else if (!stall) begin
      bus.dadoLido        <= (bus.memRead && !mis) ? load_val : 32'h0;
      bus.resultadoAlu    <= bus.endereco;
      bus.destinoReg      <= bus.destinoRegIn;
      bus.regWrite        <= bus.regWriteIn & ~mis;
      bus.memToReg        <= bus.memToRegIn;
      bus.erroAlinhamento <= mis;
    end
  end

  assign bus.registrado = bus.memToReg ? bus.dadoLido : bus.resultadoAlu;

endmodule

// File: tb/tb_mem_estagio.sv
// Bench for mem_estagio: byte-array reference model, expected-queue scoreboard,
// directed cases followed by randomized traffic and a mid-traffic reset.
module tb_mem_estagio;

  localparam int W = 104;

  logic clock;
  logic reset;
  logic stall;
  logic flush;

  mem_estagio_if bus ();

  mem_estagio #(.ADDR_W(10)) dut (
    .clock (clock),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // reference model state
  logic [7:0]  mb [4096];
  logic [31:0] m_dl, m_ra;
  logic [4:0]  m_dst;
  logic        m_rw, m_m2r, m_err;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] pack(input logic [31:0] dl, ra, input logic [4:0] dst,
                                        input logic rw, m2r, err, input logic [31:0] reg_v);
    return {dl, ra, dst, rw, m2r, err, reg_v};
  endfunction

  function automatic logic [11:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
    logic [11:0] ea;
    ea = a[11:0];
    if (sz == 2'b01) ea[0] = 1'b0;
    else if (sz[1]) ea[1:0] = 2'b00;
    return ea;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic us);
    logic [11:0] ea;
    logic [31:0] v;
    ea = eff_addr(a, sz);
    if (sz == 2'b00) begin
      v = {24'h0, mb[ea]};
      if (!us && v[7]) v = v - 32'd256;
    end else if (sz == 2'b01) begin
      v = {16'h0, mb[ea + 12'd1], mb[ea]};
      if (!us && v[15]) v = v - 32'd65536;
    end else begin
      v = {mb[ea + 12'd3], mb[ea + 12'd2], mb[ea + 12'd1], mb[ea]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [11:0] ea;
    int n;
    ea = eff_addr(a, sz);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[ea + 12'(i)] = d[8*i +: 8];
  endtask

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz, input logic rd, wr);
`ifdef MEM_ALIGN_CHECK_EN
    if (!(rd || wr)) return 1'b0;
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0 & (rd | wr | a[0] | sz[0]);
`endif
  endfunction

  // driver: one pipeline slot per call, expected MEM/WB contents pushed for the monitor
  task automatic issue(input logic st, fl, rd, wr, m2r, rw, us, input logic [1:0] sz,
                       input logic [31:0] a, d, input logic [4:0] dst);
    logic mis;
    logic [31:0] ld;
    @(negedge clock);
    stall = st;
    flush = fl;
    bus.memRead = rd;
    bus.memWrite = wr;
    bus.memToRegIn = m2r;
    bus.regWriteIn = rw;
    bus.semSinal = us;
    bus.tamanho = sz;
    bus.endereco = a;
    bus.dadoEscrita = d;
    bus.destinoRegIn = dst;
    mis = model_mis(a, sz, rd, wr);
    if (fl) begin
      m_dl = 0; m_ra = 0; m_dst = 0; m_rw = 0; m_m2r = 0; m_err = 0;
    end else if (!st) begin
      ld = (rd && !mis) ? model_load(a, sz, us) : 32'h0;
      if (wr && !mis) model_store(a, sz, d);
      m_dl = ld; m_ra = a; m_dst = dst; m_rw = rw & ~mis; m_m2r = m2r; m_err = mis;
    end
    exp_q.push_back(pack(m_dl, m_ra, m_dst, m_rw, m_m2r, m_err, m_m2r ? m_dl : m_ra));
  endtask

  task automatic idle();
    @(negedge clock);
    stall = 1'b1;
    flush = 1'b0;
    bus.memWrite = 1'b0;
    bus.memRead = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [W-1:0] act;
    act = pack(bus.dadoLido, bus.resultadoAlu, bus.destinoReg, bus.regWrite,
               bus.memToReg, bus.erroAlinhamento, bus.registrado);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s got=%h required=0", name, act);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clock);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] act, expv;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act = pack(bus.dadoLido, bus.resultadoAlu, bus.destinoReg, bus.regWrite,
                   bus.memToReg, bus.erroAlinhamento, bus.registrado);
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL memwb got=%h required=%h (dl,ra,dst,rw,m2r,err,reg)", act, expv);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bus.memRead = 0; bus.memWrite = 0; bus.memToRegIn = 0; bus.regWriteIn = 0;
    bus.semSinal = 0; bus.tamanho = 0; bus.endereco = 0; bus.dadoEscrita = 0;
    bus.destinoRegIn = 0;
    m_dl = 0; m_ra = 0; m_dst = 0; m_rw = 0; m_m2r = 0; m_err = 0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    @(negedge clock);
    reset = 1'b1;

    // fill the exercised region (0x000-0x07F) so every later load reads defined data
    for (int w = 0; w < 32; w++)
      issue(0, 0, 0, 1, 0, 0, 0, 2'b10, 32'(4 * w), $urandom, 5'(w));

    issue(0, 0, 0, 1, 0, 0, 0, 2'b10, 32'h10, 32'hDEADBEEF, 5'd1);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h10, 32'h0, 5'd2);
    issue(0, 0, 0, 1, 0, 0, 0, 2'b10, 32'h20, 32'h0, 5'd0);
    issue(0, 0, 0, 1, 0, 0, 0, 2'b00, 32'h21, 32'h7F, 5'd0);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b00, 32'h21, 32'h0, 5'd3);
    issue(0, 0, 0, 1, 0, 0, 0, 2'b00, 32'h22, 32'h80, 5'd0);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b00, 32'h22, 32'h0, 5'd4);
    issue(0, 0, 1, 0, 1, 1, 1, 2'b00, 32'h22, 32'h0, 5'd5);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h20, 32'h0, 5'd6);
    issue(0, 0, 0, 1, 0, 0, 0, 2'b01, 32'h32, 32'hABCD, 5'd0);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b01, 32'h32, 32'h0, 5'd7);
    issue(0, 0, 1, 0, 1, 1, 1, 2'b01, 32'h32, 32'h0, 5'd8);
    issue(0, 0, 0, 0, 0, 1, 0, 2'b10, 32'h1234, 32'h0, 5'd9);
    issue(1, 0, 0, 1, 0, 1, 0, 2'b10, 32'h40, 32'h5, 5'd10);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h40, 32'h0, 5'd11);
    issue(1, 1, 0, 1, 1, 1, 0, 2'b10, 32'h44, 32'h9, 5'd12);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h44, 32'h0, 5'd13);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h42, 32'h0, 5'd14);
    issue(0, 0, 0, 1, 0, 0, 0, 2'b10, 32'h41, 32'h11223344, 5'd0);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h40, 32'h0, 5'd15);
    issue(0, 0, 1, 1, 1, 1, 0, 2'b10, 32'h48, 32'h55AA55AA, 5'd16);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'h48, 32'h0, 5'd17);
    issue(0, 0, 1, 0, 1, 1, 0, 2'b01, 32'h4B, 32'h0, 5'd18);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 15) << 12) | $urandom_range(0, 127);
      sz = 2'($urandom_range(0, 3));
      issue($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            sz, a, $urandom, 5'($urandom));
    end
    idle();
    drain();

    // reset mid-traffic with a store to 0x10 pending: outputs clear, store is dropped
    @(negedge clock);
    stall = 0; flush = 0;
    bus.memWrite = 1; bus.memRead = 0; bus.tamanho = 2'b10;
    bus.endereco = 32'h10; bus.dadoEscrita = 32'hCAFEF00D;
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clock);
    #1;
    check_zero("reset_hold");
    @(negedge clock);
    bus.memWrite = 0;
    stall = 1;
    reset = 1'b1;
    m_dl = 0; m_ra = 0; m_dst = 0; m_rw = 0; m_m2r = 0; m_err = 0;

    for (int w = 0; w < 32; w++)
      issue(0, 0, 1, 0, 1, 1, 0, 2'b10, 32'(4 * w), 32'h0, 5'(w));
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
